bram_axis_reader: RTL and testbench
===================================

Name: bram_axis_reader

Overview:
- MM2S-side stage of the AXI DMA test path; sits directly downstream of the 128-bit dual-port BRAM read port.
- On a start command it reads a contiguous run of 128-bit words from BRAM port A and emits them as an AXI4-Stream master, with tlast on the final beat.
- Absorbs the BRAM's one-cycle synchronous read latency under stream backpressure using a small credit-controlled output FIFO.
- Sustains one beat per cycle while tready=1.

Parameters:
- ADDR_W, 12, BRAM word-address width; must match the BRAM instance.
- LEN_W, ADDR_W+1, width of the transfer length in words; allows a full 2^ADDR_W transfer.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 4.

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on an accepted start
- len  in  LEN_W  number of 128-bit words, latched on an accepted start
- busy  out  1  high from the edge after an accepted start until done
- done  out  1  one-cycle pulse after the last beat handshakes
- bram_en  out  1  BRAM port A read enable
- bram_addr  out  ADDR_W  BRAM port A address
- bram_rdata  in  128  BRAM port A data, valid the cycle after bram_en
- m_axis_tdata  out  128  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tlast  out  1  high on the final beat only
- m_axis_tkeep  out  16  constant all-ones

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State returns to IDLE; FIFO is emptied; counters and in-flight flag are cleared.
  - busy=0, done=0, bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
- States:
  - IDLE: start=1 latches base_addr and len. If len=0, go to DONE with no reads and no beats. Otherwise go to RUN.
  - RUN: issue reads. After the read for the last word is issued, go to FLUSH.
  - FLUSH: no reads issued. When the FIFO is empty and no read is in flight, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done pulses.
- Read issue:
  - In RUN, bram_en=1 in a cycle iff (FIFO occupancy + in-flight reads) < FIFO_DEPTH and words remain to issue.
  - bram_addr starts at base_addr and increments by 1 per issued read, modulo 2^ADDR_W; it wraps from all-ones to 0.
- Capture: a registered in-flight flag marks that bram_rdata is valid in the current cycle; that word is pushed into the FIFO at the following edge.
- Stream output:
  - tdata is the FIFO head; tvalid = FIFO not empty.
  - A beat is popped when tvalid && tready.
  - tdata, tvalid and tlast stay stable while tvalid=1 and tready=0.
- tlast:
  - A beat counter tracks popped beats.
  - tlast=1 only while the head beat is number len (1-based); tlast=0 whenever tvalid=0.
- Latency:
  - Start sampled at edge E0 → bram_en=1 with bram_addr=base during E0..E1.
  - Data is pushed at E2 → tvalid=1 after E2.
  - With tready held at 1, beats are back-to-back, one per cycle.
  - done pulses in the cycle after the tlast handshake edge.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave occupancy unchanged.
  - A start arriving while busy=1, or during the done cycle, is ignored.
- Data integrity: no beat is dropped or duplicated under any tready pattern.

Decomposition:
- Shared package dma_pkg:
  - DATA_W=128 and KEEP_W=DATA_W/8.
  - State enum {IDLE, RUN, FLUSH, DONE}.
  - Helper constant for the all-ones keep value.
- Natural sub-module: sync_fifo_128, a FIFO_DEPTH-entry synchronous FIFO with push/pop/full/empty/count, asynchronous active-low reset, and same-cycle push+pop support.
- The reader instantiates one sync_fifo_128 and contains the FSM, address/issue counters and beat counter.

Test Plan:
- Preload mem[0x10..0x13]=A0..A3; base=0x10, len=4, tready=1 → beats A0,A1,A2,A3 on 4 consecutive cycles, tlast only on A3, first tvalid after E2, single done pulse.
- Same transfer with tready pattern 1,0,0,1,0,1,1,… → exactly 4 beats in order, data held stable while stalled, at most 4 reads outstanding+buffered, tlast on A3.
- base=0xFFE, len=4 → bram_addr sequence 0xFFE,0xFFF,0x000,0x001; beats match those words in order.
- len=0 → no bram_en, no tvalid, done pulses one cycle after start, busy low again afterwards.
- start pulsed again mid-transfer with base=0x40 → ignored; the original transfer completes unchanged; a subsequent start after done is accepted.
- rst_n asserted after 2 of 8 beats → all outputs zero immediately; after release, a new len=2 transfer produces exactly 2 beats with correct tlast.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA test-path stream stages.
// 128-bit data path, keep width, and the reader state encoding.
package dma_pkg;

   localparam int DATA_W = 128;
   localparam int KEEP_W = DATA_W / 8;

   localparam logic [KEEP_W-1:0] KEEP_ALL = '1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/bram_axis_reader_if.sv
// AXI4-Stream bundle carried by the reader's output.
// The master drives data, valid, last and keep; the slave drives ready.
interface bram_axis_reader_if;
   import dma_pkg::*;

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;
   logic [KEEP_W-1:0] tkeep;

   modport master (
      output tdata,
      output tvalid,
      output tlast,
      output tkeep,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tvalid,
      input  tlast,
      input  tkeep,
      output tready
   );

endinterface

// File: rtl/sync_fifo_128.sv
// Small synchronous FIFO for 128-bit words, first-word-fall-through head.
// Push and pop in the same cycle leave the occupancy unchanged.
module sync_fifo_128
   import dma_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     pop,
   output logic [DATA_W-1:0]        rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: nothing is visible until count_q says so.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/bram_axis_reader.sv
// Reads a contiguous run of 128-bit BRAM words and streams them out as AXI4-Stream.
// A credit check (occupancy + in-flight < depth) hides the one-cycle BRAM read latency.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; latches base_addr and len
//   RUN   | issuing reads while words remain and the FIFO has credit
//   FLUSH | all reads issued; draining in-flight word and FIFO
//   DONE  | one-cycle done pulse, then back to IDLE
module bram_axis_reader
   import dma_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int LEN_W      = ADDR_W + 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [LEN_W-1:0]      len,
   output logic                  busy,
   output logic                  done,
   output logic                  bram_en,
   output logic [ADDR_W-1:0]     bram_addr,
   input  logic [DATA_W-1:0]     bram_rdata,
   bram_axis_reader_if.master    m_axis
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  issue_rem_q, issue_rem_d;
   logic [LEN_W-1:0]  beat_rem_q, beat_rem_d;
   logic              inflight_q, inflight_d;

   logic              issue;
   logic              pop;
   logic              push;
   logic              credit_ok;
   logic [CNT_W-1:0]  occupancy;
   logic [DATA_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   sync_fifo_128 #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (bram_rdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // A word in flight already owns a FIFO slot, so it counts against credit.
   assign occupancy = fifo_count + CNT_W'(inflight_q);
   assign credit_ok = (occupancy < CNT_W'(FIFO_DEPTH));
   assign push      = inflight_q && !fifo_full;
   assign pop       = !fifo_empty && m_axis.tready;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      issue_rem_d = issue_rem_q;
      beat_rem_d  = beat_rem_q;
      issue       = 1'b0;

      if (pop) begin
         beat_rem_d = beat_rem_q - LEN_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d      = base_addr;
               issue_rem_d = len;
               beat_rem_d  = len;
               state_d     = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if ((issue_rem_q != '0) && credit_ok) begin
               issue       = 1'b1;
               addr_d      = addr_q + ADDR_W'(1);
               issue_rem_d = issue_rem_q - LEN_W'(1);
               if (issue_rem_q == LEN_W'(1)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            // Leave on the final handshake so done lands in the very next cycle.
            if ((fifo_empty && !inflight_q) || (pop && (beat_rem_q == LEN_W'(1)))) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      inflight_d = issue;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         issue_rem_q <= '0;
         beat_rem_q  <= '0;
         inflight_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         issue_rem_q <= issue_rem_d;
         beat_rem_q  <= beat_rem_d;
         inflight_q  <= inflight_d;
      end
   end

   assign busy      = (state_q == RUN) || (state_q == FLUSH);
   assign done      = (state_q == DONE);
   assign bram_en   = issue;
   assign bram_addr = addr_q;

   assign m_axis.tvalid = !fifo_empty;
   assign m_axis.tdata  = fifo_empty ? '0 : fifo_rdata;
   assign m_axis.tlast  = !fifo_empty && (beat_rem_q == LEN_W'(1));
   assign m_axis.tkeep  = KEEP_ALL;

endmodule

// File: tb/tb_bram_axis_reader.sv
// Scoreboard bench for bram_axis_reader: a behavioural BRAM, directed and random
// transfers, and a negedge monitor that pops expected beats and addresses.
module tb_bram_axis_reader;
   import dma_pkg::*;

   localparam int ADDR_W = 12;
   localparam int LEN_W  = 13;
   localparam int DEPTH  = 4;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic              l;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [LEN_W-1:0]  len = '0;
   logic              tready = 1'b1;
   logic              busy, done, bram_en;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_rdata = '0;

   logic [DATA_W-1:0] mem [1 << ADDR_W];

   beat_t             exp_q [$];
   logic [ADDR_W-1:0] exp_addr_q [$];

   int n_vec = 0;
   int n_err = 0;
   int tr_mode = 0;
   int issued = 0;
   int popped = 0;

   bram_axis_reader_if axis_if ();
   assign axis_if.tready = tready;

   bram_axis_reader #(
      .ADDR_W     (ADDR_W),
      .LEN_W      (LEN_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .bram_en    (bram_en),
      .bram_addr  (bram_addr),
      .bram_rdata (bram_rdata),
      .m_axis     (axis_if)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_en) bram_rdata <= mem[bram_addr];
   end

   // Ready pattern changes just after the edge, so the monitor sees the value used at the next edge.
   logic [6:0] pat = 7'b1101001;
   int pi = 0;
   always begin
      @(posedge clk);
      #1;
      case (tr_mode)
         0: tready = 1'b1;
         1: tready = 1'($urandom_range(0, 1));
         default: begin
            tready = pat[pi];
            pi = (pi + 1) % 7;
         end
      endcase
   end

   task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   logic              stall_prev = 1'b0;
   logic [DATA_W-1:0] hold_d = '0;
   logic              hold_l = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
         issued = 0;
         popped = 0;
      end else begin
         chk("tkeep", DATA_W'(axis_if.tkeep), DATA_W'(KEEP_ALL));
         if (!axis_if.tvalid) chk("tlast_idle", DATA_W'(axis_if.tlast), '0);
         if (stall_prev) begin
            chk("hold_valid", DATA_W'(axis_if.tvalid), 1);
            chk("hold_data", axis_if.tdata, hold_d);
            chk("hold_last", DATA_W'(axis_if.tlast), DATA_W'(hold_l));
         end
         if (bram_en) begin
            issued++;
            chk("outstanding", DATA_W'((issued - popped) <= DEPTH), 1);
            if (exp_addr_q.size() == 0) begin
               chk("addr_unexpected", DATA_W'(bram_addr), '1);
            end else begin
               chk("bram_addr", DATA_W'(bram_addr), DATA_W'(exp_addr_q.pop_front()));
            end
         end
         if (axis_if.tvalid && tready) begin
            beat_t e;
            popped++;
            if (exp_q.size() == 0) begin
               chk("beat_unexpected", axis_if.tdata, '1);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", axis_if.tdata, e.d);
               chk("beat_last", DATA_W'(axis_if.tlast), DATA_W'(e.l));
            end
         end
         stall_prev = axis_if.tvalid && !tready;
         hold_d = axis_if.tdata;
         hold_l = axis_if.tlast;
      end
   end

   // Expected response from the transfer definition alone: words base..base+len-1 modulo the BRAM size.
   task automatic issue(input logic [ADDR_W-1:0] b, input int l, input bit accept);
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      len = LEN_W'(l);
      if (accept) begin
         for (int i = 0; i < l; i++) begin
            beat_t e;
            logic [ADDR_W-1:0] a;
            a = b + ADDR_W'(i);
            e.d = mem[a];
            e.l = (i == l - 1);
            exp_q.push_back(e);
            exp_addr_q.push_back(a);
         end
      end
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(negedge clk);
         n++;
         if (done) break;
      end
      if (!done) chk("done_timeout", DATA_W'(n), DATA_W'(budget + 1));
   endtask

   task automatic finish_xfer(input int budget);
      int n;
      wait_done(budget, n);
      @(negedge clk);
      chk("done_pulse", DATA_W'(done), '0);
      chk("busy_after", DATA_W'(busy), '0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_busy"}, DATA_W'(busy), '0);
      chk({tag, "_done"}, DATA_W'(done), '0);
      chk({tag, "_bram_en"}, DATA_W'(bram_en), '0);
      chk({tag, "_bram_addr"}, DATA_W'(bram_addr), '0);
      chk({tag, "_tvalid"}, DATA_W'(axis_if.tvalid), '0);
      chk({tag, "_tlast"}, DATA_W'(axis_if.tlast), '0);
      chk({tag, "_tdata"}, axis_if.tdata, '0);
   endtask

   initial begin
      int n;
      int k;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         mem[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int i = 0; i < 4; i++) begin
         mem[12'h010 + i] = {4{32'hA000_0000 + 32'(i)}};
      end

      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Directed: base 0x10, len 4, ready held high, latency checked.
      tr_mode = 0;
      issue(12'h010, 4, 1'b1);
      @(negedge clk);
      chk("e0_bram_en", DATA_W'(bram_en), 1);
      chk("e0_busy", DATA_W'(busy), 1);
      chk("e0_tvalid", DATA_W'(axis_if.tvalid), '0);
      @(negedge clk);
      chk("e1_tvalid", DATA_W'(axis_if.tvalid), '0);
      @(negedge clk);
      chk("e2_tvalid", DATA_W'(axis_if.tvalid), 1);
      chk("e2_tdata", axis_if.tdata, {4{32'hA000_0000}});
      wait_done(50, n);
      chk("done_latency", DATA_W'(n), 4);
      @(negedge clk);
      chk("done_width", DATA_W'(done), '0);
      chk("busy_idle", DATA_W'(busy), '0);

      // Same transfer under the 1,0,0,1,0,1,1 ready pattern.
      tr_mode = 2;
      issue(12'h010, 4, 1'b1);
      finish_xfer(100);

      // Address wrap from all-ones to zero.
      tr_mode = 1;
      issue(12'hFFE, 4, 1'b1);
      finish_xfer(100);

      // Zero-length: no reads, no beats, done one cycle after start.
      tr_mode = 0;
      issue(12'h123, 0, 1'b1);
      @(negedge clk);
      chk("len0_done", DATA_W'(done), 1);
      chk("len0_bram_en", DATA_W'(bram_en), '0);
      chk("len0_tvalid", DATA_W'(axis_if.tvalid), '0);
      @(negedge clk);
      chk("len0_done_width", DATA_W'(done), '0);
      chk("len0_busy", DATA_W'(busy), '0);

      // Start while busy and during the done cycle are both ignored.
      tr_mode = 2;
      issue(12'h020, 6, 1'b1);
      repeat (2) @(negedge clk);
      start = 1'b1; base_addr = 12'h040; len = LEN_W'(3);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(200, n);
      start = 1'b1; base_addr = 12'h050; len = LEN_W'(2);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk("ign_busy", DATA_W'(busy), '0);
      chk("ign_done", DATA_W'(done), '0);
      chk("ign_bram_en", DATA_W'(bram_en), '0);
      @(negedge clk);
      chk("ign_busy2", DATA_W'(busy), '0);
      issue(12'h040, 3, 1'b1);
      finish_xfer(100);

      // Reset mid-transfer after two beats, then a fresh len=2 transfer.
      tr_mode = 0;
      issue(12'h080, 8, 1'b1);
      k = 0;
      while (popped < 2 && k < 100) begin
         @(posedge clk);
         k++;
      end
      chk("reset_reach", DATA_W'(popped >= 2), 1);
      #2 rst_n = 1'b0;
      #1 chk_outputs_zero("midrst");
      exp_q.delete();
      exp_addr_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      issue(12'h090, 2, 1'b1);
      finish_xfer(100);

      // Random transfers under mixed backpressure.
      for (int t = 0; t < 25; t++) begin
         int l;
         tr_mode = (t % 4 == 0) ? 0 : 1;
         l = $urandom_range(1, 24);
         issue(ADDR_W'($urandom), l, 1'b1);
         finish_xfer(l * 40 + 40);
      end

      repeat (3) @(negedge clk);
      chk("sb_beats_left", DATA_W'(exp_q.size()), '0);
      chk("sb_addrs_left", DATA_W'(exp_addr_q.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
